// File: rtl/sort_pkg.sv
// Shared types and sizing for the sequential 8-word descending sorter.
package sort_pkg;
  localparam int WIDTH = 16;
  localparam int N     = 8;
  localparam int PH_W  = $clog2(N);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SORT = 2'd1,
    DONE = 2'd2
  } state_e;
endpackage

// File: rtl/sort8_desc_seq_cmp_swap_w.sv
// Combinational compare-swap cell: larger word leaves on hi when enabled.
module cmp_swap_w #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         en,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo,
  output logic         swp
);
  // Equal words never swap, so the ordering of duplicates is preserved.
  assign swp = en & (a < b);
  assign hi  = swp ? b : a;
  assign lo  = swp ? a : b;
endmodule

// File: rtl/sort8_desc_seq.sv
// Odd-even transposition sorter: parallel load, N phases, then hold result.
// Handshakes: a transfer happens on a rising edge where valid and ready are both high.
module sort8_desc_seq
  import sort_pkg::*;
#(
  parameter int W  = sort_pkg::WIDTH,
  parameter int NW = sort_pkg::N
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [NW*W-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [NW*W-1:0] out_data,
  output logic [NW-2:0]   swap_flags
);
  state_e          state_q, state_d;
  logic [PH_W-1:0] phase_q, phase_d;
  logic [W-1:0]    w_q [NW];
  logic [W-1:0]    w_d [NW];

  logic [NW-2:0]   pair_en;
  logic [W-1:0]    hi   [NW-1];
  logic [W-1:0]    lo   [NW-1];
  logic [NW-2:0]   swp;

  // Pair (k,k+1) is compared when k has the same parity as the phase.
  always_comb begin
    pair_en = '0;
    for (int k = 0; k < NW-1; k++) begin
      pair_en[k] = (state_q == SORT) && (phase_q[0] == k[0]);
    end
  end

  for (genvar k = 0; k < NW-1; k++) begin : g_cell
    cmp_swap_w #(.W(W)) u_cell (
      .a   (w_q[k]),
      .b   (w_q[k+1]),
      .en  (pair_en[k]),
      .hi  (hi[k]),
      .lo  (lo[k]),
      .swp (swp[k])
    );
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    for (int i = 0; i < NW; i++) w_d[i] = w_q[i];
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          for (int i = 0; i < NW; i++) w_d[i] = in_data[i*W +: W];
          phase_d = '0;
          state_d = SORT;
        end
      end
      SORT: begin
        // Enabled pairs are disjoint, so each word takes at most one cell output.
        for (int i = 0; i < NW; i++) begin
          if (i > 0 && pair_en[i-1])       w_d[i] = lo[i-1];
          else if (i < NW-1 && pair_en[i]) w_d[i] = hi[i];
        end
        phase_d = phase_q + 1'b1;
        if (phase_q == PH_W'(NW-1)) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      phase_q <= '0;
      for (int i = 0; i < NW; i++) w_q[i] <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      for (int i = 0; i < NW; i++) w_q[i] <= w_d[i];
    end
  end

  always_comb begin
    out_data = '0;
    for (int i = 0; i < NW; i++) out_data[i*W +: W] = w_q[i];
  end

  assign in_ready   = (state_q == IDLE) && !rst;
  assign out_valid  = (state_q == DONE);
  assign swap_flags = swp;
endmodule

// File: tb/tb_sort8_desc_seq.sv
// Directed bench for sort8_desc_seq with hand-computed expected vectors.
module tb_sort8_desc_seq;
  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic [6:0]   swap_flags;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sort8_desc_seq dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .swap_flags (swap_flags)
  );

  function automatic logic [127:0] pk(input logic [15:0] a0, a1, a2, a3, a4, a5, a6, a7);
    return {a7, a6, a5, a4, a3, a2, a1, a0};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present d and wait for acceptance; returns the handshake edge index and any
  // result seen on out_valid while waiting. Ends at the negedge after the handshake.
  task automatic load_wait(input logic [127:0] d, output int edge_idx, output logic [127:0] seen);
    int n;
    n = 0;
    seen = '0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && n < 50) begin
      if (out_valid) seen = out_data;
      @(negedge clk);
      n++;
    end
    chk("load_timeout", 128'(n < 50), 128'(1));
    @(negedge clk);
    edge_idx = cyc;
    in_valid = 1'b0;
  endtask

  // Count edges from the handshake edge until out_valid; OR up swap_flags on the way.
  task automatic wait_valid(output int n, output logic [6:0] sw_or);
    n = 1;
    sw_or = swap_flags;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
      sw_or |= swap_flags;
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("drain_in_ready", 128'(in_ready), 128'(1));
    chk("drain_out_valid", 128'(out_valid), 128'(0));
  endtask

  initial begin
    int t1, t2, n;
    logic [6:0]   sw;
    logic [127:0] seen, exp_r;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    @(negedge clk);
    chk("rst_in_ready_low", 128'(in_ready), 128'(0));
    in_valid = 1'b1; in_data = pk(1, 2, 3, 4, 5, 6, 7, 8);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_out_data", out_data, 128'(0));
    chk("rst_swap", 128'(swap_flags), 128'(0));

    // Reverse order, latency, and the first two phase swap patterns.
    load_wait(pk(0, 1, 2, 3, 4, 5, 6, 7), t1, seen);
    chk("rev_busy_ready", 128'(in_ready), 128'(0));
    chk("rev_swap_ph0", 128'(swap_flags), 128'(7'b1010101));
    @(negedge clk);
    chk("rev_swap_ph1", 128'(swap_flags), 128'(7'b0101010));
    wait_valid(n, sw);
    chk("rev_latency", 128'(n + 1), 128'(9));
    chk("rev_data", out_data, pk(7, 6, 5, 4, 3, 2, 1, 0));
    chk("done_swap", 128'(swap_flags), 128'(0));
    drain();

    // Duplicates and unsigned extremes.
    load_wait(pk(16'h0000, 16'hFFFF, 16'h8000, 16'h8000, 16'h0001, 16'hFFFF, 16'h7FFF, 16'h0000), t1, seen);
    wait_valid(n, sw);
    chk("dup_latency", 128'(n), 128'(9));
    chk("dup_data", out_data, pk(16'hFFFF, 16'hFFFF, 16'h8000, 16'h8000, 16'h7FFF, 16'h0001, 16'h0000, 16'h0000));
    drain();

    // Already sorted: no swap decisions ever.
    load_wait(pk(7, 6, 5, 4, 3, 2, 1, 0), t1, seen);
    wait_valid(n, sw);
    chk("sorted_swaps", 128'(sw), 128'(0));
    chk("sorted_data", out_data, pk(7, 6, 5, 4, 3, 2, 1, 0));
    drain();

    // Backpressure for 20 cycles.
    load_wait(pk(5, 3, 9, 1, 9, 0, 2, 8), t1, seen);
    wait_valid(n, sw);
    exp_r = pk(9, 9, 8, 5, 3, 2, 1, 0);
    for (int i = 0; i < 20; i++) begin
      chk("bp_valid", 128'(out_valid), 128'(1));
      chk("bp_data", out_data, exp_r);
      chk("bp_in_ready", 128'(in_ready), 128'(0));
      @(negedge clk);
    end
    drain();

    // Reset at phase 3.
    load_wait(pk(1, 2, 3, 4, 5, 6, 7, 8), t1, seen);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_in_ready", 128'(in_ready), 128'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_valid", 128'(out_valid), 128'(0));
    chk("post_rst_data", out_data, 128'(0));
    chk("post_rst_in_ready", 128'(in_ready), 128'(1));
    load_wait(pk(16'h0010, 16'h0300, 16'h0020, 16'h1000, 16'h0001, 16'h0200, 16'h4000, 16'h0002), t1, seen);
    wait_valid(n, sw);
    chk("post_rst_sort", out_data, pk(16'h4000, 16'h1000, 16'h0300, 16'h0200, 16'h0020, 16'h0010, 16'h0002, 16'h0001));
    drain();

    // Load pulse during SORT is ignored.
    load_wait(pk(3, 1, 4, 1, 5, 9, 2, 6), t1, seen);
    @(negedge clk);
    in_valid = 1'b1; in_data = pk(100, 200, 300, 400, 500, 600, 700, 800);
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    wait_valid(n, sw);
    chk("busy_latency", 128'(n + 3), 128'(9));
    chk("busy_data", out_data, pk(9, 6, 5, 4, 3, 2, 1, 1));
    drain();

    // Back-to-back loads with out_ready tied high.
    out_ready = 1'b1;
    load_wait(pk(8, 16'hA000, 2, 16'hFFFE, 4, 16'h0100, 6, 16'h8001), t1, seen);
    load_wait(pk(11, 22, 33, 44, 55, 66, 77, 88), t2, seen);
    chk("b2b_first", seen, pk(16'hFFFE, 16'hA000, 16'h8001, 16'h0100, 8, 6, 4, 2));
    chk("b2b_interval", 128'(t2 - t1), 128'(10));
    load_wait(pk(0, 0, 0, 0, 0, 0, 0, 0), t1, seen);
    chk("b2b_second", seen, pk(88, 77, 66, 55, 44, 33, 22, 11));
    out_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
